// File: rtl/execute_stage_pkg.sv
// Shared definitions for the execute stage: opcodes, FSM states, default widths
// and opcode classification helpers.
package execute_stage_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int ADDR_W_DEF = 3;

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_AND = 4'd2;
  localparam logic [3:0] OP_OR  = 4'd3;
  localparam logic [3:0] OP_XOR = 4'd4;
  localparam logic [3:0] OP_SHL = 4'd5;
  localparam logic [3:0] OP_SHR = 4'd6;
  localparam logic [3:0] OP_MOV = 4'd7;
  localparam logic [3:0] OP_MUL = 4'd8;
  localparam logic [3:0] OP_CMP = 4'd9;
  localparam logic [3:0] OP_NOP = 4'd10;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_MUL  = 1'b1
  } state_e;

  // Ops that produce a result (and may write back): everything up to MUL.
  function automatic logic op_stores(input logic [3:0] op);
    return op <= OP_MUL;
  endfunction

  // CMP updates flags without storing; opcodes past CMP are NOPs.
  function automatic logic op_sets_flags(input logic [3:0] op);
    return op <= OP_CMP;
  endfunction

endpackage

// File: rtl/execute_stage_seq_multiplier.sv
// Iterative shift-add multiplier: one partial product per cycle, MUL_CYCLES steps.
// o_Done/o_Product are valid in the cycle before the edge that applies the last step.
module execute_stage_seq_multiplier #(
  parameter int DATA_W     = 8,
  parameter int MUL_CYCLES = 8
) (
  input  logic                  i_CLK,
  input  logic                  i_RST,
  input  logic                  i_Start,
  input  logic [DATA_W-1:0]     i_A,
  input  logic [DATA_W-1:0]     i_B,
  output logic                  o_Done,
  output logic [2*DATA_W-1:0]   o_Product
);

  localparam int CNT_W = $clog2(MUL_CYCLES + 1);

  logic                  busy_q;
  logic [CNT_W-1:0]      cnt_q;
  logic [2*DATA_W-1:0]   acc_q, acc_d;
  logic [2*DATA_W-1:0]   mcand_q;
  logic [DATA_W-1:0]     mplier_q;

  // Product output already includes the step taken on the completing edge.
  assign acc_d     = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
  assign o_Done    = busy_q && (cnt_q == CNT_W'(MUL_CYCLES - 1));
  assign o_Product = acc_d;

  always_ff @(posedge i_CLK) begin
    if (i_RST) begin
      busy_q   <= 1'b0;
      cnt_q    <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
    end else if (i_Start) begin
      busy_q   <= 1'b1;
      cnt_q    <= '0;
      acc_q    <= '0;
      mcand_q  <= {{DATA_W{1'b0}}, i_A};
      mplier_q <= i_B;
    end else if (busy_q) begin
      acc_q    <= acc_d;
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
      cnt_q    <= cnt_q + CNT_W'(1);
      if (o_Done) busy_q <= 1'b0;
    end
  end

endmodule

// File: rtl/execute_stage.sv
// Execute stage: single-cycle ALU plus iterative multiply, driving the register
// bank write-back port with write data lagging the write flag by one cycle.
module execute_stage
  import execute_stage_pkg::*;
#(
  parameter int DATA_W     = DATA_W_DEF,
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int MUL_CYCLES = DATA_W_DEF
) (
  input  logic              i_CLK,
  input  logic              i_RST,
  input  logic              i_Valid,
  input  logic [3:0]        i_Opcode,
  input  logic [DATA_W-1:0] i_Operand1,
  input  logic [DATA_W-1:0] i_Operand2,
  input  logic [ADDR_W-1:0] i_AddrRegDest,
  input  logic              i_WriteEnable,
  output logic              o_Ready,
  output logic              o_WriteBack,
  output logic [ADDR_W-1:0] o_AddrRegDest,
  output logic [DATA_W-1:0] o_WriteData,
  output logic              o_Zero,
  output logic              o_Carry
);

  state_e              state_q;
  logic                wb_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   res_q;
  logic [DATA_W-1:0]   wdata_q;
  logic                zero_q, carry_q;
  logic [ADDR_W-1:0]   mul_dest_q;
  logic                mul_we_q;

  logic                mul_start, mul_done;
  logic [2*DATA_W-1:0] mul_prod;
  logic [DATA_W:0]     alu_w;

  logic                cmpl_flags, cmpl_store, cmpl_wb, cmpl_c;
  logic [DATA_W-1:0]   cmpl_res;
  logic [ADDR_W-1:0]   cmpl_addr;

  assign mul_start = (state_q == ST_IDLE) && i_Valid && (i_Opcode == OP_MUL);

  execute_stage_seq_multiplier #(
    .DATA_W     (DATA_W),
    .MUL_CYCLES (MUL_CYCLES)
  ) u_mul (
    .i_CLK     (i_CLK),
    .i_RST     (i_RST),
    .i_Start   (mul_start),
    .i_A       (i_Operand1),
    .i_B       (i_Operand2),
    .o_Done    (mul_done),
    .o_Product (mul_prod)
  );

  // ALU result with carry/borrow in the top bit.
  always_comb begin
    alu_w = '0;
    case (i_Opcode)
      OP_ADD:         alu_w = {1'b0, i_Operand1} + {1'b0, i_Operand2};
      OP_SUB, OP_CMP: alu_w = {1'b0, i_Operand1} - {1'b0, i_Operand2};
      OP_AND:         alu_w = {1'b0, i_Operand1 & i_Operand2};
      OP_OR:          alu_w = {1'b0, i_Operand1 | i_Operand2};
      OP_XOR:         alu_w = {1'b0, i_Operand1 ^ i_Operand2};
      OP_SHL:         alu_w = {i_Operand1, 1'b0};
      OP_SHR:         alu_w = {i_Operand1[0], 1'b0, i_Operand1[DATA_W-1:1]};
      OP_MOV:         alu_w = {1'b0, i_Operand2};
      default:        alu_w = '0;
    endcase
  end

  // Select what completes on this edge: a finishing multiply or an accepted ALU op.
  always_comb begin
    cmpl_flags = 1'b0;
    cmpl_store = 1'b0;
    cmpl_wb    = 1'b0;
    cmpl_res   = alu_w[DATA_W-1:0];
    cmpl_c     = alu_w[DATA_W];
    cmpl_addr  = i_AddrRegDest;
    if (state_q == ST_MUL) begin
      cmpl_res  = mul_prod[DATA_W-1:0];
      cmpl_c    = |mul_prod[2*DATA_W-1:DATA_W];
      cmpl_addr = mul_dest_q;
      if (mul_done) begin
        cmpl_flags = 1'b1;
        cmpl_store = 1'b1;
        cmpl_wb    = mul_we_q;
      end
    end else if (i_Valid && (i_Opcode != OP_MUL)) begin
      cmpl_flags = op_sets_flags(i_Opcode);
      cmpl_store = op_stores(i_Opcode);
      cmpl_wb    = i_WriteEnable && op_stores(i_Opcode);
    end
  end

  always_ff @(posedge i_CLK) begin
    if (i_RST) begin
      state_q    <= ST_IDLE;
      wb_q       <= 1'b0;
      addr_q     <= '0;
      res_q      <= '0;
      wdata_q    <= '0;
      zero_q     <= 1'b0;
      carry_q    <= 1'b0;
      mul_dest_q <= '0;
      mul_we_q   <= 1'b0;
    end else begin
      wb_q    <= cmpl_wb;
      // Data trails the flag by one edge to match the bank's internal delay.
      wdata_q <= res_q;
      if (cmpl_store) begin
        res_q  <= cmpl_res;
        addr_q <= cmpl_addr;
      end
      if (cmpl_flags) begin
        zero_q  <= (cmpl_res == '0);
        carry_q <= cmpl_c;
      end
      case (state_q)
        ST_IDLE: if (mul_start) begin
          state_q    <= ST_MUL;
          mul_dest_q <= i_AddrRegDest;
          mul_we_q   <= i_WriteEnable;
        end
        ST_MUL: if (mul_done) state_q <= ST_IDLE;
      endcase
    end
  end

  assign o_Ready       = (state_q == ST_IDLE);
  assign o_WriteBack   = wb_q;
  assign o_AddrRegDest = addr_q;
  assign o_WriteData   = wdata_q;
  assign o_Zero        = zero_q;
  assign o_Carry       = carry_q;

endmodule

// File: tb/tb_execute_stage.sv
// Self-checking bench for execute_stage: directed scenarios plus randomized ops
// against an arithmetic reference model and a register-bank model.
module tb_execute_stage;

  logic       clk = 1'b0;
  logic       rst;
  logic       valid;
  logic [3:0] opc;
  logic [7:0] op1, op2;
  logic [2:0] dest;
  logic       we;
  logic       ready, wb_o, zero_o, carry_o;
  logic [2:0] addr_o;
  logic [7:0] wdata_o;

  int checks = 0;
  int errors = 0;

  logic       bank_clr = 1'b0;
  logic       bank_wb_q = 1'b0;
  logic [2:0] bank_addr_q = '0;
  logic [7:0] bank_regs [8];
  logic [7:0] exp_regs  [8];

  execute_stage #(.DATA_W(8), .ADDR_W(3), .MUL_CYCLES(8)) dut (
    .i_CLK(clk), .i_RST(rst), .i_Valid(valid), .i_Opcode(opc),
    .i_Operand1(op1), .i_Operand2(op2), .i_AddrRegDest(dest), .i_WriteEnable(we),
    .o_Ready(ready), .o_WriteBack(wb_o), .o_AddrRegDest(addr_o),
    .o_WriteData(wdata_o), .o_Zero(zero_o), .o_Carry(carry_o)
  );

  always #5 clk = ~clk;

  // Register bank: flag/address captured one edge, data written the next.
  always @(posedge clk) begin
    bank_wb_q   <= wb_o;
    bank_addr_q <= addr_o;
    if (bank_clr) begin
      for (int i = 0; i < 8; i++) bank_regs[i] <= 8'hA0 + 8'(i);
    end else if (bank_wb_q) begin
      bank_regs[bank_addr_q] <= wdata_o;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  function automatic void ref_op(input int op, input int a, input int b,
                                 output int res, output bit c, output bit fl, output bit st);
    int full;
    full = 0;
    c = 1'b0;
    case (op)
      0:    begin full = a + b; c = (full > 255); end
      1, 9: begin full = a - b; c = (a < b); end
      2:    full = a & b;
      3:    full = a | b;
      4:    full = a ^ b;
      5:    begin full = a * 2; c = (a >= 128); end
      6:    begin full = a / 2; c = (a % 2 == 1); end
      7:    full = b;
      8:    begin full = a * b; c = (full > 255); end
      default: full = 0;
    endcase
    res = full & 255;
    fl  = (op <= 9);
    st  = (op <= 8);
  endfunction

  task automatic do_bank_clr();
    bank_clr = 1'b1;
    @(posedge clk); #1;
    bank_clr = 1'b0;
    for (int i = 0; i < 8; i++) exp_regs[i] = 8'hA0 + 8'(i);
  endtask

  // Issue one op (stage must be ready) and observe it through completion and data lag.
  task automatic run_op(input logic [3:0] o, input logic [7:0] a, input logic [7:0] b,
                        input logic [2:0] d, input logic e,
                        output int lat, output int wbcnt, output logic wb,
                        output logic [2:0] ad, output logic [7:0] wd, output logic z, output logic c);
    valid = 1'b1; opc = o; op1 = a; op2 = b; dest = d; we = e;
    lat = 0; wbcnt = 0;
    @(posedge clk); #1;
    valid = 1'b0;
    op1 = 8'($urandom_range(0, 255)); op2 = 8'($urandom_range(0, 255));
    dest = 3'($urandom_range(0, 7));
    while (!ready && lat < 20) begin
      wbcnt += int'(wb_o);
      @(posedge clk); #1;
      lat++;
    end
    wb = wb_o; ad = addr_o;
    wbcnt += int'(wb_o);
    @(posedge clk); #1;
    wd = wdata_o; z = zero_o; c = carry_o;
    wbcnt += int'(wb_o);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (wb_o !== 1'b0)    begin errors++; $display("FAIL reset_wb: got %b want 0", wb_o); end
    checks++; if (addr_o !== 3'd0)  begin errors++; $display("FAIL reset_addr: got %h want 0", addr_o); end
    checks++; if (wdata_o !== 8'd0) begin errors++; $display("FAIL reset_wdata: got %h want 0", wdata_o); end
    checks++; if (zero_o !== 1'b0)  begin errors++; $display("FAIL reset_zero: got %b want 0", zero_o); end
    checks++; if (carry_o !== 1'b0) begin errors++; $display("FAIL reset_carry: got %b want 0", carry_o); end
    checks++; if (ready !== 1'b1)   begin errors++; $display("FAIL reset_ready: got %b want 1", ready); end
    rst = 1'b0;
    do_bank_clr();
  endtask

  task automatic test_add();
    int lat, wbc; logic wb, z, c; logic [2:0] ad; logic [7:0] wd;
    run_op(4'd0, 8'hF0, 8'h20, 3'd3, 1'b1, lat, wbc, wb, ad, wd, z, c);
    checks++; if (wb !== 1'b1)   begin errors++; $display("FAIL add_wb: got %b want 1", wb); end
    checks++; if (ad !== 3'd3)   begin errors++; $display("FAIL add_addr: got %h want 3", ad); end
    checks++; if (wd !== 8'h10)  begin errors++; $display("FAIL add_wdata: got %h want 10", wd); end
    checks++; if (c !== 1'b1 || z !== 1'b0) begin errors++; $display("FAIL add_flags: got c=%b z=%b want c=1 z=0", c, z); end
    checks++; if (wbc !== 1)     begin errors++; $display("FAIL add_pulse: got %0d pulses want 1", wbc); end
    @(posedge clk); #1;
    checks++; if (bank_regs[3] !== 8'h10) begin errors++; $display("FAIL add_bank_r3: got %h want 10", bank_regs[3]); end
  endtask

  task automatic test_back_to_back();
    do_bank_clr();
    valid = 1'b1; opc = 4'd2; op1 = 8'h0F; op2 = 8'h3C; dest = 3'd1; we = 1'b1;
    @(posedge clk); #1;
    checks++; if (wb_o !== 1'b1 || addr_o !== 3'd1) begin errors++; $display("FAIL b2b_and_wb: got wb=%b addr=%h want 1/1", wb_o, addr_o); end
    opc = 4'd4; op1 = 8'hFF; op2 = 8'hFF; dest = 3'd2;
    @(posedge clk); #1;
    valid = 1'b0;
    checks++; if (wb_o !== 1'b1 || addr_o !== 3'd2) begin errors++; $display("FAIL b2b_xor_wb: got wb=%b addr=%h want 1/2", wb_o, addr_o); end
    checks++; if (wdata_o !== 8'h0C) begin errors++; $display("FAIL b2b_and_data: got %h want 0C", wdata_o); end
    @(posedge clk); #1;
    checks++; if (wdata_o !== 8'h00 || zero_o !== 1'b1) begin errors++; $display("FAIL b2b_xor_data: got %h z=%b want 00 z=1", wdata_o, zero_o); end
    checks++; if (wb_o !== 1'b0) begin errors++; $display("FAIL b2b_pulse_end: got %b want 0", wb_o); end
    @(posedge clk); #1;
    checks++; if (bank_regs[1] !== 8'h0C) begin errors++; $display("FAIL b2b_bank_r1: got %h want 0C", bank_regs[1]); end
    checks++; if (bank_regs[2] !== 8'h00) begin errors++; $display("FAIL b2b_bank_r2: got %h want 00", bank_regs[2]); end
  endtask

  task automatic test_mul();
    int lat, wbc; logic wb, z, c; logic [2:0] ad; logic [7:0] wd;
    run_op(4'd8, 8'h12, 8'h0A, 3'd5, 1'b1, lat, wbc, wb, ad, wd, z, c);
    checks++; if (lat !== 8)    begin errors++; $display("FAIL mul_latency: got %0d want 8", lat); end
    checks++; if (wbc !== 1 || wb !== 1'b1) begin errors++; $display("FAIL mul_pulse: got %0d pulses wb=%b want 1", wbc, wb); end
    checks++; if (ad !== 3'd5)  begin errors++; $display("FAIL mul_addr: got %h want 5", ad); end
    checks++; if (wd !== 8'hB4) begin errors++; $display("FAIL mul_data: got %h want B4", wd); end
    checks++; if (c !== 1'b0 || z !== 1'b0) begin errors++; $display("FAIL mul_flags: got c=%b z=%b want 0/0", c, z); end
  endtask

  task automatic test_mul_hold();
    int early;
    valid = 1'b1; opc = 4'd8; op1 = 8'h80; op2 = 8'h04; dest = 3'd4; we = 1'b1;
    @(posedge clk); #1;
    opc = 4'd0; op1 = 8'h01; op2 = 8'h02; dest = 3'd6;
    early = 0;
    repeat (7) begin @(posedge clk); #1; early += int'(wb_o); end
    checks++; if (early !== 0) begin errors++; $display("FAIL hold_early: got %0d pulses want 0", early); end
    @(posedge clk); #1;
    checks++; if (wb_o !== 1'b1 || addr_o !== 3'd4) begin errors++; $display("FAIL hold_mul_wb: got wb=%b addr=%h want 1/4", wb_o, addr_o); end
    checks++; if (zero_o !== 1'b1 || carry_o !== 1'b1) begin errors++; $display("FAIL hold_mul_flags: got z=%b c=%b want 1/1", zero_o, carry_o); end
    @(posedge clk); #1;
    valid = 1'b0;
    checks++; if (wb_o !== 1'b1 || addr_o !== 3'd6) begin errors++; $display("FAIL hold_add_wb: got wb=%b addr=%h want 1/6", wb_o, addr_o); end
    checks++; if (wdata_o !== 8'h00) begin errors++; $display("FAIL hold_mul_data: got %h want 00", wdata_o); end
    @(posedge clk); #1;
    checks++; if (wdata_o !== 8'h03 || zero_o !== 1'b0 || carry_o !== 1'b0) begin
      errors++; $display("FAIL hold_add_data: got %h z=%b c=%b want 03 0 0", wdata_o, zero_o, carry_o); end
  endtask

  task automatic test_cmp_nop();
    int lat, wbc; logic wb, z, c; logic [2:0] ad; logic [7:0] wd;
    run_op(4'd0, 8'hF0, 8'h20, 3'd3, 1'b1, lat, wbc, wb, ad, wd, z, c);
    run_op(4'd9, 8'h05, 8'h05, 3'd7, 1'b1, lat, wbc, wb, ad, wd, z, c);
    checks++; if (wbc !== 0) begin errors++; $display("FAIL cmp_wb: got %0d pulses want 0", wbc); end
    checks++; if (z !== 1'b1 || c !== 1'b0) begin errors++; $display("FAIL cmp_flags: got z=%b c=%b want 1/0", z, c); end
    run_op(4'd12, 8'h80, 8'h01, 3'd6, 1'b1, lat, wbc, wb, ad, wd, z, c);
    checks++; if (wbc !== 0) begin errors++; $display("FAIL nop_wb: got %0d pulses want 0", wbc); end
    checks++; if (z !== 1'b1 || c !== 1'b0) begin errors++; $display("FAIL nop_flags: got z=%b c=%b want 1/0", z, c); end
  endtask

  task automatic test_reset_mid_mul();
    int lat, wbc, cnt; logic wb, z, c; logic [2:0] ad; logic [7:0] wd;
    valid = 1'b1; opc = 4'd8; op1 = 8'hFF; op2 = 8'hFF; dest = 3'd2; we = 1'b1;
    @(posedge clk); #1;
    valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++; if (wb_o !== 1'b0 || addr_o !== 3'd0 || wdata_o !== 8'd0) begin
      errors++; $display("FAIL rstmul_outs: got wb=%b addr=%h data=%h want 0", wb_o, addr_o, wdata_o); end
    checks++; if (zero_o !== 1'b0 || carry_o !== 1'b0) begin errors++; $display("FAIL rstmul_flags: got z=%b c=%b want 0/0", zero_o, carry_o); end
    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL rstmul_ready: got %b want 1", ready); end
    cnt = 0;
    repeat (10) begin @(posedge clk); #1; cnt += int'(wb_o); end
    checks++; if (cnt !== 0) begin errors++; $display("FAIL rstmul_stray_wb: got %0d pulses want 0", cnt); end
    run_op(4'd0, 8'h03, 8'h04, 3'd1, 1'b1, lat, wbc, wb, ad, wd, z, c);
    checks++; if (wb !== 1'b1 || ad !== 3'd1 || wd !== 8'h07) begin
      errors++; $display("FAIL rstmul_add: got wb=%b addr=%h data=%h want 1 1 07", wb, ad, wd); end
  endtask

  task automatic test_random();
    int lat, wbc, res; bit mc, mz, rc, fl, st, wr;
    logic wb, z, c; logic [2:0] ad; logic [7:0] wd;
    logic [3:0] o; logic [7:0] a, b; logic [2:0] d; logic e;
    do_bank_clr();
    run_op(4'd0, 8'h00, 8'h00, 3'd0, 1'b0, lat, wbc, wb, ad, wd, z, c);
    checks++; if (z !== 1'b1 || c !== 1'b0 || wbc !== 0) begin errors++; $display("FAIL rand_seed_op: got z=%b c=%b pulses=%0d want 1 0 0", z, c, wbc); end
    mz = 1'b1; mc = 1'b0;
    for (int n = 0; n < 60; n++) begin
      o = 4'($urandom_range(0, 15)); a = 8'($urandom_range(0, 255)); b = 8'($urandom_range(0, 255));
      d = 3'($urandom_range(0, 7)); e = 1'($urandom_range(0, 1));
      ref_op(int'(o), int'(a), int'(b), res, rc, fl, st);
      wr = e && st;
      if (fl) begin mz = (res == 0); mc = rc; end
      if (wr) exp_regs[d] = 8'(res);
      run_op(o, a, b, d, e, lat, wbc, wb, ad, wd, z, c);
      checks++; if (lat !== ((o == 4'd8) ? 8 : 0)) begin errors++; $display("FAIL rand%0d_latency: op=%0d got %0d", n, o, lat); end
      checks++; if (wbc !== int'(wr) || wb !== wr) begin errors++; $display("FAIL rand%0d_wb: op=%0d got %0d pulses wb=%b want %b", n, o, wbc, wb, wr); end
      checks++; if (z !== mz || c !== mc) begin errors++; $display("FAIL rand%0d_flags: op=%0d got z=%b c=%b want z=%b c=%b", n, o, z, c, mz, mc); end
      if (st) begin
        checks++; if (ad !== d || wd !== 8'(res)) begin
          errors++; $display("FAIL rand%0d_data: op=%0d got addr=%h data=%h want addr=%h data=%h", n, o, ad, wd, d, 8'(res)); end
      end
    end
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 8; i++) begin
      checks++; if (bank_regs[i] !== exp_regs[i]) begin errors++; $display("FAIL rand_bank_r%0d: got %h want %h", i, bank_regs[i], exp_regs[i]); end
    end
  endtask

  initial begin
    rst = 1'b1; valid = 1'b0; opc = '0; op1 = '0; op2 = '0; dest = '0; we = 1'b0;
    test_reset();
    test_add();
    test_back_to_back();
    test_mul();
    test_mul_hold();
    test_cmp_nop();
    test_reset_mid_mul();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/execute_stage.md
Name: execute_stage

Overview:
- Execute stage of the 8-bit CPU datapath. Sits directly downstream of the register bank.
- Consumes the two operands read from the bank, performs the ALU operation selected by decode, and drives the bank's write-back interface (write flag, destination address, write data).
- The write-back timing matches the bank's internal one-cycle delay on the write flag and address.
- Single-cycle ALU ops, plus an iterative 8-cycle shift-add multiply that stalls the front end.

Parameters:
- DATA_W, 8, operand/result width
- ADDR_W, 3, register address width (8 registers)
- MUL_CYCLES, 8, multiply iterations; must equal DATA_W

Ports:
- i_CLK  input  1  system clock, rising-edge
- i_RST  input  1  reset, synchronous, active-high
- i_Valid  input  1  decode presents an op this cycle
- i_Opcode  input  4  ALU operation code
- i_Operand1  input  DATA_W  first operand (bank o_Data1)
- i_Operand2  input  DATA_W  second operand (bank o_Data2)
- i_AddrRegDest  input  ADDR_W  destination register
- i_WriteEnable  input  1  op writes its result to a register
- o_Ready  output  1  stage can accept an op this cycle
- o_WriteBack  output  1  to bank i_WriteBack; one-cycle pulse per write
- o_AddrRegDest  output  ADDR_W  to bank i_AddrRegDest
- o_WriteData  output  DATA_W  to bank i_WriteData
- o_Zero  output  1  zero flag of the last completed op
- o_Carry  output  1  carry/borrow flag of the last completed op

Behaviour:
- Reset (i_RST high at a rising edge):
  - all outputs go to 0 except o_Ready, which goes to 1
  - state goes to IDLE
  - an in-flight multiply is discarded with no write-back
- Accept: an op is accepted at an edge where i_Valid && o_Ready.
- Opcodes:
  - 0 ADD
  - 1 SUB (op1-op2; carry = borrow)
  - 2 AND
  - 3 OR
  - 4 XOR
  - 5 SHL op1 by 1 (carry = bit7)
  - 6 SHR op1 by 1 (carry = bit0)
  - 7 MOV (result = op2)
  - 8 MUL (low 8 bits of op1*op2; carry = 1 if the high byte is nonzero)
  - 9 CMP (SUB that updates flags only, never writes back)
  - 10-15 NOP (no flag update, no write-back)
- Arithmetic and flags:
  - arithmetic is modulo 2^DATA_W
  - o_Zero = (8-bit result == 0)
  - logic ops and MOV clear carry
- State machine:
  - IDLE: o_Ready=1. Accepting a non-MUL op completes it at the accept edge T. Accepting a MUL loads the multiplicand, multiplier and a 4-bit counter, then moves to MUL.
  - MUL: o_Ready=0. One shift-add step per cycle. On the edge where the counter reaches MUL_CYCLES, the op completes and the state returns to IDLE, so the completion edge is T+8. An op cannot be accepted on that completion edge; the next op can be accepted one cycle later.
- Completion at edge C:
  - o_WriteBack <= i_WriteEnable && opcode is neither CMP nor NOP
  - o_AddrRegDest <= destination; flags update
  - the result is stored internally
  - o_WriteBack is a one-cycle pulse
- Data lag: o_WriteData <= stored result at edge C+1, one edge after the write flag. The bank captures the flag and address at C+1 and writes o_WriteData at C+2.
- Hold: o_WriteData and o_AddrRegDest hold their value until the next completion.
- Back-to-back single-cycle ops, accepted every cycle, must each write the correct value. The lag register guarantees this.
- Operands and i_AddrRegDest are sampled only at the accept edge. Changes on them during MUL are ignored.
- i_Valid while o_Ready=0: the op is not accepted. Decode must hold it until it is.
- Reset mid-MUL: state goes to IDLE, o_WriteBack stays 0, o_WriteData goes to 0, and the flags clear.

Decomposition:
- Shared package: opcode constants (OP_ADD..OP_NOP), DATA_W/ADDR_W defaults, state encoding (ST_IDLE, ST_MUL).
- One natural sub-module: seq_multiplier.
  - contains the shift-add datapath, counter and done strobe
  - ports: i_CLK, i_RST, i_Start, i_A, i_B, o_Done, o_Product[15:0]
- The ALU case statement and the write-back registers stay in execute_stage.

Test Plan:
- ADD op1=0xF0, op2=0x20, dest=3, WE=1 -> o_WriteBack=1 with o_AddrRegDest=3 the cycle after accept. Next cycle o_WriteData=0x10, o_Carry=1, o_Zero=0. The bank model then reads R3=0x10.
- Back-to-back: AND 0x0F&0x3C->R1, then XOR 0xFF^0xFF->R2 on consecutive cycles -> R1=0x0C, R2=0x00, o_Zero=1 after the second op. No corruption of R1.
- MUL op1=0x12, op2=0x0A, dest=5 -> o_Ready low for 8 cycles. o_WriteBack pulses once at T+8. o_WriteData=0xB4, carry=0.
- MUL 0x80*0x04 -> result 0x00, carry=1, zero=1. An i_Valid ADD held during the MUL is accepted only after o_Ready returns to 1.
- CMP 0x05 vs 0x05 with WE=1 -> o_WriteBack stays 0, o_Zero=1, o_Carry=0. An opcode 12 op leaves the flags unchanged.
- Assert i_RST at the 4th MUL cycle -> no write-back pulse. All outputs read 0 and o_Ready reads 1 after the edge, and a subsequent ADD executes normally.
